// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned FETCH_XLEN = 32;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Entry width for a core whose PC width differs from FETCH_XLEN.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return INSTR_W + xlen;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-memory read port, decode handshake and redirect.
interface fetch_if import fetch_pkg::*; #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = 8
) ();

  logic               o_imem_req;
  logic [IMEM_AW-1:0] o_imem_addr;
  logic [INSTR_W-1:0] i_imem_data;
  logic               o_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [XLEN-1:0]    o_pc;
  logic               i_redirect;
  logic [XLEN-1:0]    i_redirect_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    input  i_imem_data, i_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    output i_imem_data, i_ready, i_redirect, i_redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO: head is read before the same-edge write, so
// push+pop is legal even when full. Flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualified push/pop and status flags.
  always_comb begin
    o_empty   = (count_r == {CW{1'b0}});
    o_full    = (count_r == CW'(DEPTH));
    do_pop_s  = i_pop && !o_empty;
    do_push_s = i_push && (!o_full || do_pop_s);
    o_count   = count_r;
    if (o_empty) begin
      o_data = {WIDTH{1'b0}};
    end else begin
      o_data = mem_r[rd_ptr_r];
    end
  end

  // Storage write; contents need no reset because count gates the read side.
  always_ff @(posedge i_clk) begin
    if (do_push_s && !i_flush && !i_reset) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + {{(CW-1){1'b0}}, do_push_s} - {{(CW-1){1'b0}}, do_pop_s};
    end
  end

  fetch_fifo_chk u_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_push),
    .i_pop   (i_pop),
    .i_flush (i_flush),
    .i_full  (o_full),
    .i_empty (o_empty)
  );

endmodule

// Protocol checks for fetch_fifo.
module fetch_fifo_chk (
  input logic i_clk,
  input logic i_reset,
  input logic i_push,
  input logic i_pop,
  input logic i_flush,
  input logic i_full,
  input logic i_empty
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset || i_flush)
    !(i_push && i_full && !i_pop));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset || i_flush)
    !(i_pop && i_empty));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem request, prefetch FIFO, redirect.
// Define FETCH_PERF_EN to add o_fetch_count / o_flush_count.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned    XLEN       = 32,
  parameter int unsigned    IMEM_AW    = 8,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
  input  logic       i_clk,
  input  logic       i_reset,
  fetch_if.master    bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_flush_count
`endif
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = entry_width(XLEN);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } entry_t;

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic            inflight_vld_r;

  entry_t          push_entry_s;
  entry_t          head_entry_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            pop_s;
  logic            issue_s;
  logic [CW:0]     occ_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Issue control: a request may only go out if its word is guaranteed a slot.
  always_comb begin
    pop_s         = !fifo_empty_s && bus.i_ready;
    occ_s         = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_vld_r};
    redirect_pc_s = bus.i_redirect_pc & ~XLEN'(32'd3);
    push_entry_s  = '{instr: bus.i_imem_data, pc: inflight_pc_r};
    if (!i_reset && !bus.i_redirect && (occ_s < DEPTH_C + {{CW{1'b0}}, pop_s})) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign bus.o_imem_req  = issue_s;
  assign bus.o_imem_addr = pc_r[IMEM_AW+1:2];
  assign bus.o_valid     = !fifo_empty_s;
  assign bus.o_instr     = head_entry_s.instr;
  assign bus.o_pc        = head_entry_s.pc;

  // PC and in-flight tracking; redirect drops the word returning next cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_r           <= RESET_PC;
      inflight_pc_r  <= {XLEN{1'b0}};
      inflight_vld_r <= 1'b0;
    end else if (bus.i_redirect) begin
      pc_r           <= redirect_pc_s;
      inflight_vld_r <= 1'b0;
    end else if (issue_s) begin
      inflight_pc_r  <= pc_r;
      inflight_vld_r <= 1'b1;
      pc_r           <= pc_r + XLEN'(32'd4);
    end else begin
      inflight_vld_r <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (inflight_vld_r),
    .i_data  (push_entry_s),
    .i_pop   (pop_s),
    .i_flush (bus.i_redirect),
    .o_data  (head_entry_s),
    .o_count (fifo_count_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s)
  );

`ifdef FETCH_PERF_EN
  // Accepted-word and redirect counters, wrapping at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fetch_count <= 32'd0;
      o_flush_count <= 32'd0;
    end else begin
      if (pop_s)          o_fetch_count <= o_fetch_count + 32'd1;
      if (bus.i_redirect) o_flush_count <= o_flush_count + 32'd1;
    end
  end
`endif

endmodule
